// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds operation codes, FSM states and operand-signedness helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module md_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         quot_bit
);
    logic [W:0] shifted;
    logic [W:0] trial;

    assign shifted = {rem, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};

    // rem < divisor keeps shifted below 2*divisor, so trial[W] is a clean borrow.
    assign quot_bit = ~trial[W];
    assign rem_next = quot_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider, one iteration per cycle, valid/ready on both sides, flushable.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    MDResult
);
    localparam int           W         = DATA_WIDTH;
    localparam logic [W-1:0] LAST_ITER = W'(W - 1);
    localparam logic [W-1:0] MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    md_state_e      state, next_state;
    md_op_e         op_in, op_q;
    logic           div_op, sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;
    logic           special_hit;
    logic [W-1:0]   special_val;
    logic           accept, busy, last_iter;

    logic [2*W-1:0] acc;
    logic [W-1:0]   operand_q;
    logic [W-1:0]   count;
    logic           neg_q, rem_neg_q;
    logic [W-1:0]   md_result_q;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next, div_next, iter_next, product;
    logic [W-1:0]   step_rem;
    logic           step_bit;
    logic [W-1:0]   final_val;

    assign op_in  = md_op_e'(Operation[2:0]);
    assign div_op = op_in[2];
    assign sign_a = is_signed_a(op_in) && SrcA[W-1];
    assign sign_b = is_signed_b(op_in) && SrcB[W-1];
    assign mag_a  = sign_a ? -SrcA : SrcA;
    assign mag_b  = sign_b ? -SrcB : SrcB;

    assign accept    = in_valid && (state == ST_IDLE) && !flush;
    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign last_iter = busy && (count == LAST_ITER);

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        special_hit = 1'b0;
        special_val = '0;
        if (div_op && SrcB == '0) begin
            special_hit = 1'b1;
            special_val = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : SrcA;
        end else if ((op_in == OP_DIV || op_in == OP_REM) && SrcA == MOST_NEG && SrcB == '1) begin
            special_hit = 1'b1;
            special_val = (op_in == OP_DIV) ? SrcA : '0;
        end else if (!div_op && (SrcA == '0 || SrcB == '0)) begin
            special_hit = 1'b1;
        end
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand_q} : '0);
    assign mul_next = {mul_sum, acc[W-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits in}.
    md_div_step #(.W(W)) u_div_step (
        .rem          (acc[2*W-1:W]),
        .dividend_bit (acc[W-1]),
        .divisor      (operand_q),
        .rem_next     (step_rem),
        .quot_bit     (step_bit)
    );
    assign div_next = {step_rem, acc[W-2:0], step_bit};

    assign iter_next = (state == ST_MUL) ? mul_next : div_next;
    assign product   = neg_q ? -iter_next : iter_next;

    // The sign fix is folded into the last iteration edge.
    always_comb begin
        final_val = product[2*W-1:W];
        case (op_q)
            OP_MUL:          final_val = product[W-1:0];
            OP_DIV, OP_DIVU: final_val = neg_q ? -iter_next[W-1:0] : iter_next[W-1:0];
            OP_REM, OP_REMU: final_val = rem_neg_q ? -iter_next[2*W-1:W] : iter_next[2*W-1:W];
            default:         ;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid) next_state = special_hit ? ST_DONE : (div_op ? ST_DIV : ST_MUL);
            ST_MUL,
            ST_DIV:  if (last_iter) next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_MUL;
            acc         <= '0;
            operand_q   <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            md_result_q <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q      <= op_in;
                count     <= '0;
                neg_q     <= sign_a ^ sign_b;
                rem_neg_q <= sign_a;
                if (div_op) begin
                    operand_q <= mag_b;
                    acc       <= {{W{1'b0}}, mag_a};
                end else begin
                    operand_q <= mag_a;
                    acc       <= {{W{1'b0}}, mag_b};
                end
                if (special_hit) md_result_q <= special_val;
            end else if (busy) begin
                acc   <= iter_next;
                count <= count + W'(1);
                if (last_iter) md_result_q <= final_val;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign MDResult  = md_result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, back-pressure,
// flush and reset cases, then randomized operations against an arithmetic model.
module tb_muldiv_unit;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  Operation = 3'd0;
    logic [31:0] SrcA      = 32'd0;
    logic [31:0] SrcB      = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] MDResult;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MDResult  (MDResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2])
            return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    // Compare process: whenever a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                check("model", MDResult, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", in_ready, 1);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk);
        exp_q.push_back(model(op, a, b));
        #1;
        in_valid  = 1'b0;
        Operation = 3'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    // Latency counts the accept cycle as cycle 1.
    task automatic finish_op(input int hold, input int exp_lat, input bit lit_en,
                             input logic [31:0] lit, input string name);
        int          lat = 1;
        logic [31:0] held;
        bit          bad = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        if (lit_en) check(name, MDResult, lit);
        held = MDResult;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (MDResult !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        if (hold > 0) check({name, "_hold"}, bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_idle_after"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run_lit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit, input int lat, input int hold, input string name);
        out_ready = (hold == 0);
        issue(op, a, b);
        finish_op(hold, lat, 1'b1, lit, name);
    endtask

    task automatic watch_quiet(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check(name, seen, 0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", MDResult, 0);
        rst_n = 1'b1;

        run_lit(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "mul_7_m3");
        run_lit(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0, "mulh_min_min");
        run_lit(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, "mulhsu_ones");
        run_lit(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, "mulhu_ones");
        run_lit(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0, "div_m7_2");
        run_lit(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0, "rem_m7_2");
        run_lit(3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1,  0, "div_by_zero");
        run_lit(3'd6, 32'd5,          32'd0,         32'd5,         1,  0, "rem_by_zero");
        run_lit(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0, "div_overflow");
        run_lit(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0, "rem_overflow");
        run_lit(3'd0, 32'd0,          32'h1234_5678, 32'd0,         1,  0, "mul_zero");

        // Back-pressure for 10 cycles, then a back-to-back accept.
        run_lit(3'd5, 32'd100,        32'd7,         32'd14,        33, 10, "divu_100_7_bp");
        run_lit(3'd7, 32'd100,        32'd7,         32'd2,         33, 0,  "remu_100_7");

        // Flush at iteration 10 of a DIV.
        out_ready = 1'b1;
        issue(3'd4, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {out_valid, in_ready}, 2'b01);
        exp_q.delete();
        watch_quiet("flush_no_result");
        run_lit(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0, "div_after_flush");

        // Asynchronous reset in the middle of a MULHU.
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", {out_valid, in_ready}, 2'b01);
        check("rst_mid_result", MDResult, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rst_no_result");
        run_lit(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0, "mulhsu_after_rst");

        // Randomized operations with random back-pressure.
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          hold;
            op   = 3'($urandom);
            a    = rand_operand();
            b    = rand_operand();
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            out_ready = (hold == 0);
            issue(op, a, b);
            finish_op(hold, is_special(op, a, b) ? 1 : 33, 1'b0, 32'd0, "rand");
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
